minicpu_issue_unit: RTL and testbench
=====================================

Name: minicpu_issue_unit

Overview:
- Sequencing front end that produces the operation stream consumed by the mini-CPU ALU.
- Accepts packed 16-bit instruction words over a valid/ready handshake and decodes them.
- Reads operands from an internal 4 x 16-bit signed register file, drives the ALU opcode/operand inputs, and writes the ALU result back.
- Executes LOAD, CLEAR and DISPLAY locally; DISPLAY is presented on a back-pressured output port.

Parameters:
- DATA_W, 16, register/ALU datapath width; fixed by ALU, not to be overridden.
- NUM_REGS, 4, register count; fixed by 2-bit register fields.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  unit can accept; high only in IDLE.
- instr  in  16  [15:13] opcode, [12:11] rd, [10:9] rs1, [8:7] rs2 (reg/reg ops), [8:0] imm9 (LOAD/ADDI/SUBI/MUL, sign-extended).
- alu_opcode  out  3  opcode to ALU.
- alu_a  out  16  signed operand A = R[rs1].
- alu_b  out  16  signed operand B = R[rs2] or sext(imm9).
- alu_result  in  16  signed combinational ALU result.
- alu_zero  in  1  ALU zero flag.
- disp_valid  out  1  display word pending.
- disp_ready  in  1  display sink accepts.
- disp_data  out  16  value being displayed.
- wb_valid  out  1  one-cycle pulse per register-file write.
- wb_addr  out  2  register written.
- wb_data  out  16  value written.
- zero_flag  out  1  sticky zero status of the last ALU/CLEAR write.

Behaviour:
- Opcodes: 000 LOAD, 001 ADD, 010 ADDI, 011 SUB, 100 SUBI, 101 MUL (reg/imm), 110 CLEAR, 111 DISPLAY.
- Reset state: state=IDLE; all registers 0; zero_flag=1; instr_ready=1 on the first cycle after reset; disp_valid=0, disp_data=0; wb_valid=0, wb_addr=0, wb_data=0; alu_opcode=0, alu_a=0, alu_b=0.
- FSM states:
  - IDLE: instr_ready=1. On instr_valid at an edge, latch the decoded opcode, rd and operands (register-file read happens in the same cycle). DISPLAY goes to DISP; every other opcode goes to EXEC.
  - EXEC: exactly one cycle; alu_* outputs are driven from the latched values. At the closing edge:
    - ALU ops (001-101): R[rd] <= alu_result, zero_flag <= alu_zero.
    - LOAD: R[rd] <= sext(imm9); zero_flag unchanged.
    - CLEAR: all R <= 0, zero_flag <= 1.
    - Then go to IDLE.
  - DISP: disp_valid=1, disp_data = R[rs1] as latched at accept. Stay until disp_valid && disp_ready at an edge, then go to IDLE. disp_data is stable while disp_valid is high.
- wb_valid pulses for exactly the one cycle following the EXEC edge, for LOAD and ALU ops only.
  - wb_addr/wb_data hold the written register and value.
  - CLEAR and DISPLAY do not pulse.
- alu_* outputs hold their last values outside EXEC; the ALU result is sampled only in EXEC.
- Latency:
  - Non-display op accepted at edge T0 is written at edge T1, so the next accept is possible at T2; throughput is 1 instruction per 2 cycles.
  - DISPLAY occupies at least 1 cycle in DISP.
- Arithmetic: two's-complement, wraps mod 2^16 (ALU truncation). No overflow flag. imm9 range is -256..255.
- rd == rs1 (or rs2) is legal: operands are latched before the write.
- instr_valid while instr_ready=0 is ignored; the word is not consumed. The sender must hold it until the handshake completes.
- rst asserted in any state (including DISP with disp_valid high, or EXEC) returns everything to reset values at that edge. No write or display completes on that edge, and the pending display is dropped.
- disp_ready high outside DISP has no effect.

Decomposition:
- Shared package minicpu_pkg holds:
  - opcode typedef enum (OP_LOAD..OP_DISPLAY, 3 bits);
  - instruction field position/width constants;
  - DATA_W;
  - FSM state enum.
- The ALU package/enum is shared so both ends use identical opcode encodings.
- One natural sub-module: minicpu_regfile (4x16, 2 combinational read ports, 1 synchronous write port, synchronous clear-all input, synchronous reset).

Test Plan:
- LOAD r1,#5 then ADDI r1,r1,#-5 -> wb pulses (1,5) then (1,0); zero_flag=1; alu_opcode=010, alu_a=5, alu_b=0xFFFB during EXEC.
- LOAD r2,#255; MUL r3,r2,#255 -> wb (3,0xFE01) (65025 fits). LOAD r0,#200; MUL r0,r0,#200 -> 40000 mod 65536 written as 0x9C40 (-25536); zero_flag=0.
- LOAD r1,#-3; LOAD r2,#7; SUB r3,r1,r2 -> wb (3,-10 = 0xFFF6); instr_ready low for exactly 1 cycle after each accept.
- DISPLAY r3 with disp_ready low 4 cycles, then high -> disp_valid high 5 cycles, disp_data=0xFFF6 stable; back-to-back instr_valid not accepted until the cycle after the handshake.
- CLEAR after nonzero registers -> all R=0, zero_flag=1, no wb pulse; subsequent DISPLAY r2 shows 0.
- Assert rst during DISP (disp_ready low) -> next cycle disp_valid=0, instr_ready=1, registers 0; following DISPLAY r3 shows 0.

Source files
------------

// File: rtl/minicpu_pkg.sv
// rtl/minicpu_pkg.sv - shared opcode, field and FSM definitions for the mini-CPU issue path
package minicpu_pkg;
   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 4;
   localparam int REG_AW   = 2;
   localparam int IMM_W    = 9;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 13;
   localparam int RD_MSB  = 12;
   localparam int RD_LSB  = 11;
   localparam int RS1_MSB = 10;
   localparam int RS1_LSB = 9;
   localparam int RS2_MSB = 8;
   localparam int RS2_LSB = 7;
   localparam int IMM_MSB = 8;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      OP_LOAD    = 3'b000,
      OP_ADD     = 3'b001,
      OP_ADDI    = 3'b010,
      OP_SUB     = 3'b011,
      OP_SUBI    = 3'b100,
      OP_MUL     = 3'b101,
      OP_CLEAR   = 3'b110,
      OP_DISPLAY = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DISP = 2'd2
   } state_t;

   function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

   function automatic logic is_alu_op(input opcode_t op);
      return (op != OP_LOAD) && (op != OP_CLEAR) && (op != OP_DISPLAY);
   endfunction
endpackage

// File: rtl/minicpu_regfile.sv
// rtl/minicpu_regfile.sv - 4 x 16 register file, two async read ports, one sync write, sync clear-all
module minicpu_regfile
   import minicpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              clear
);
   logic [DATA_W-1:0] regs [NUM_REGS];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];
endmodule

// File: rtl/minicpu_issue_unit.sv
// rtl/minicpu_issue_unit.sv - decodes instruction words, sequences the ALU and handles LOAD/CLEAR/DISPLAY
module minicpu_issue_unit
   import minicpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [2:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              disp_valid,
   input  logic              disp_ready,
   output logic [DATA_W-1:0] disp_data,
   output logic              wb_valid,
   output logic [1:0]        wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic              zero_flag
);
   state_t            state, state_next;
   opcode_t           dec_op, op_q;
   logic [1:0]        rd_q;
   logic [DATA_W-1:0] rs1_data, rs2_data, dec_b, wr_data;
   logic              accept, exec_write, exec_alu, exec_clear;

   assign dec_op = opcode_t'(instr[OP_MSB:OP_LSB]);
   assign dec_b  = (dec_op == OP_ADD || dec_op == OP_SUB) ? rs2_data
                                                          : sext_imm(instr[IMM_MSB:IMM_LSB]);
   // LOAD carries its sign-extended immediate in the B operand latch
   assign wr_data = (op_q == OP_LOAD) ? alu_b : alu_result;

   minicpu_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .raddr_a (instr[RS1_MSB:RS1_LSB]),
      .raddr_b (instr[RS2_MSB:RS2_LSB]),
      .rdata_a (rs1_data),
      .rdata_b (rs2_data),
      .we      (exec_write),
      .waddr   (rd_q),
      .wdata   (wr_data),
      .clear   (exec_clear)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (instr_valid) state_next = (dec_op == OP_DISPLAY) ? ST_DISP : ST_EXEC;
         ST_EXEC: state_next = ST_IDLE;
         ST_DISP: if (disp_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      instr_ready = (state == ST_IDLE);
      disp_valid  = (state == ST_DISP);
      accept      = instr_ready && instr_valid;
      exec_alu    = (state == ST_EXEC) && is_alu_op(op_q);
      exec_write  = exec_alu || ((state == ST_EXEC) && (op_q == OP_LOAD));
      exec_clear  = (state == ST_EXEC) && (op_q == OP_CLEAR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= OP_LOAD;
         rd_q       <= '0;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         disp_data  <= '0;
         wb_valid   <= 1'b0;
         wb_addr    <= '0;
         wb_data    <= '0;
         zero_flag  <= 1'b1;
      end else begin
         wb_valid <= exec_write;
         if (accept) begin
            op_q <= dec_op;
            rd_q <= instr[RD_MSB:RD_LSB];
            // DISPLAY leaves the ALU inputs untouched so they keep their last values
            if (dec_op == OP_DISPLAY) begin
               disp_data <= rs1_data;
            end else begin
               alu_opcode <= dec_op;
               alu_a      <= rs1_data;
               alu_b      <= dec_b;
            end
         end
         if (exec_write) begin
            wb_addr <= rd_q;
            wb_data <= wr_data;
         end
         if (exec_alu)        zero_flag <= alu_zero;
         else if (exec_clear) zero_flag <= 1'b1;
      end
   end
endmodule

// File: tb/tb_minicpu_issue_unit.sv
// tb/tb_minicpu_issue_unit.sv - scoreboard bench for minicpu_issue_unit with a behavioural ALU
module tb_minicpu_issue_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [15:0] instr = '0;
   logic [2:0]  alu_opcode;
   logic [15:0] alu_a, alu_b, alu_result;
   logic        alu_zero;
   logic        disp_valid;
   logic        disp_ready = 1'b0;
   logic [15:0] disp_data;
   logic        wb_valid;
   logic [1:0]  wb_addr;
   logic [15:0] wb_data;
   logic        zero_flag;

   typedef struct {
      bit          is_disp;
      logic [1:0]  addr;
      logic [15:0] data;
   } exp_t;
   exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   minicpu_issue_unit dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .alu_opcode  (alu_opcode),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero),
      .disp_valid  (disp_valid),
      .disp_ready  (disp_ready),
      .disp_data   (disp_data),
      .wb_valid    (wb_valid),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .zero_flag   (zero_flag)
   );

   always #5 clk = ~clk;

   always_comb begin
      case (alu_opcode)
         3'b001, 3'b010: alu_result = alu_a + alu_b;
         3'b011, 3'b100: alu_result = alu_a - alu_b;
         3'b101:         alu_result = alu_a * alu_b;
         default:        alu_result = alu_b;
      endcase
      alu_zero = (alu_result == 16'd0);
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
      end
   endfunction

   function automatic logic [15:0] ei(input int op, input int rd, input int rs1, input int imm);
      return {op[2:0], rd[1:0], rs1[1:0], imm[8:0]};
   endfunction

   function automatic logic [15:0] rr(input int op, input int rd, input int rs1, input int rs2);
      return {op[2:0], rd[1:0], rs1[1:0], rs2[1:0], 7'b0};
   endfunction

   function automatic void push_wb(input logic [1:0] a, input logic [15:0] d);
      exp_t e;
      e.is_disp = 1'b0; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endfunction

   function automatic void push_disp(input logic [15:0] d);
      exp_t e;
      e.is_disp = 1'b1; e.addr = 2'd0; e.data = d;
      exp_q.push_back(e);
   endfunction

   // monitor: every write-back pulse and display handshake must match the queue head
   always @(negedge clk) begin
      if (!rst) begin
         if (wb_valid) begin
            if (exp_q.size() == 0 || exp_q[0].is_disp) begin
               n_cmp++; n_bad++;
               $display("FAIL wb_unexpected: got pulse addr=%0d data=0x%0h, want no pulse", wb_addr, wb_data);
            end else begin
               chk("wb_addr", wb_addr, exp_q[0].addr);
               chk("wb_data", wb_data, exp_q[0].data);
               void'(exp_q.pop_front());
            end
         end
         if (disp_valid && disp_ready) begin
            if (exp_q.size() == 0 || !exp_q[0].is_disp) begin
               n_cmp++; n_bad++;
               $display("FAIL disp_unexpected: got display 0x%0h, want none", disp_data);
            end else begin
               chk("disp_data", disp_data, exp_q[0].data);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [15:0] w);
      int n = 0;
      instr = w;
      instr_valid = 1'b1;
      while (!instr_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!instr_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: instr_ready got 0 want 1");
      end
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic do_op(input logic [15:0] w, input string name);
      send(w);
      chk({name, "_busy"}, instr_ready, 32'd0);
      @(posedge clk); #1;
      chk({name, "_ready"}, instr_ready, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_instr_ready", instr_ready, 32'd1);
      chk("rst_disp_valid",  disp_valid,  32'd0);
      chk("rst_disp_data",   disp_data,   32'd0);
      chk("rst_wb_valid",    wb_valid,    32'd0);
      chk("rst_zero_flag",   zero_flag,   32'd1);
      chk("rst_alu_opcode",  alu_opcode,  32'd0);
      chk("rst_alu_a",       alu_a,       32'd0);
      chk("rst_alu_b",       alu_b,       32'd0);
      rst = 1'b0;

      push_wb(2'd1, 16'd5);
      do_op(ei(0, 1, 0, 5), "load_r1_5");
      push_wb(2'd1, 16'd0);
      send(ei(2, 1, 1, -5));
      chk("addi_alu_opcode", alu_opcode, 32'h2);
      chk("addi_alu_a",      alu_a,      32'h5);
      chk("addi_alu_b",      alu_b,      32'hFFFB);
      @(posedge clk); #1;
      chk("addi_zero_flag",  zero_flag,  32'd1);

      push_wb(2'd2, 16'd255);
      do_op(ei(0, 2, 0, 255), "load_r2_255");
      push_wb(2'd3, 16'hFE01);
      do_op(ei(5, 3, 2, 255), "mul_r3");
      chk("mul_r3_zero_flag", zero_flag, 32'd0);
      push_wb(2'd0, 16'd200);
      do_op(ei(0, 0, 0, 200), "load_r0_200");
      push_wb(2'd0, 16'h9C40);
      do_op(ei(5, 0, 0, 200), "mul_r0_wrap");
      chk("mul_r0_zero_flag", zero_flag, 32'd0);

      push_wb(2'd1, 16'hFFFD);
      do_op(ei(0, 1, 0, -3), "load_r1_m3");
      push_wb(2'd2, 16'd7);
      do_op(ei(0, 2, 0, 7), "load_r2_7");
      push_wb(2'd3, 16'hFFF6);
      do_op(rr(3, 3, 1, 2), "sub_r3");
      chk("sub_zero_flag", zero_flag, 32'd0);

      disp_ready = 1'b0;
      push_disp(16'hFFF6);
      send(ei(7, 0, 3, 0));
      instr = ei(0, 0, 0, 1);
      instr_valid = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         chk("disp_hold_valid", disp_valid, 32'd1);
         chk("disp_hold_data",  disp_data,  32'hFFF6);
         chk("disp_hold_busy",  instr_ready, 32'd0);
         if (disp_valid) n++;
         @(posedge clk); #1;
      end
      disp_ready = 1'b1;
      if (disp_valid) n++;
      chk("disp_valid_cycles", n, 32'd5);
      @(posedge clk); #1;
      disp_ready = 1'b0;
      chk("disp_done_valid", disp_valid,  32'd0);
      chk("disp_done_ready", instr_ready, 32'd1);
      push_wb(2'd0, 16'd1);
      do_op(ei(0, 0, 0, 1), "load_after_disp");

      chk("pre_clear_zero", zero_flag, 32'd0);
      do_op(ei(6, 0, 0, 0), "clear");
      chk("clear_zero_flag", zero_flag, 32'd1);
      chk("clear_no_wb",     wb_valid,  32'd0);
      disp_ready = 1'b1;
      push_disp(16'd0);
      send(ei(7, 0, 2, 0));
      @(posedge clk); #1;
      push_disp(16'd0);
      send(ei(7, 0, 0, 0));
      @(posedge clk); #1;

      push_wb(2'd3, 16'd9);
      do_op(ei(0, 3, 0, 9), "load_r3_9");
      push_wb(2'd1, 16'd18);
      do_op(rr(1, 1, 3, 3), "add_r1");
      chk("add_zero_flag", zero_flag, 32'd0);

      disp_ready = 1'b0;
      send(ei(7, 0, 3, 0));
      chk("pre_rst_disp_valid", disp_valid, 32'd1);
      chk("pre_rst_disp_data",  disp_data,  32'd9);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_disp_valid",  disp_valid,  32'd0);
      chk("mid_rst_instr_ready", instr_ready, 32'd1);
      chk("mid_rst_disp_data",   disp_data,   32'd0);
      chk("mid_rst_zero_flag",   zero_flag,   32'd1);
      chk("mid_rst_alu_a",       alu_a,       32'd0);
      disp_ready = 1'b1;
      push_disp(16'd0);
      send(ei(7, 0, 3, 0));
      @(posedge clk); #1;
      push_disp(16'd0);
      send(ei(7, 0, 1, 0));
      @(posedge clk); #1;

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
